// File: rtl/xnor_compare_seq.sv
// Sequential masked comparator: walks two WIDTH-bit operands SLICE bits per clock
// through a NOR-built XNOR and reports equality, match count and match parity.
module xnor_compare_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4,
    localparam int NS = WIDTH / SLICE,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    output logic             busy,
    output logic             done,
    output logic             result_eq,
    output logic [CW-1:0]    match_count,
    output logic             match_parity
);

    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    // Handshake: start is accepted on a rising edge only in IDLE or DONE with clr low;
    // busy stays high for exactly NS cycles, then done pulses for one cycle with the
    // results, which hold until the next accepted start, clr or reset.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, mask_q;
    logic [IW-1:0]    idx;
    logic             eq_acc;
    logic [CW-1:0]    cnt_acc;
    logic             par_acc;

    logic [SLICE-1:0] sa, sb, sm, n1, n2, n3, xn, hit;
    logic [CW-1:0]    slice_cnt;
    logic             slice_eq;
    logic             last;

    function automatic logic [CW-1:0] popcnt(input logic [SLICE-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < SLICE; k++) c = c + CW'(v[k]);
        return c;
    endfunction

    // Four-NOR XNOR: n1 = nor(a,b); n2 = ~a&b; n3 = a&~b; xn = nor(n2,n3).
    always_comb begin
        sa        = a_q[idx*SLICE +: SLICE];
        sb        = b_q[idx*SLICE +: SLICE];
        sm        = mask_q[idx*SLICE +: SLICE];
        n1        = ~(sa | sb);
        n2        = ~(sa | n1);
        n3        = ~(sb | n1);
        xn        = ~(n2 | n3);
        hit       = xn & ~sm;
        slice_eq  = &(xn | sm);
        slice_cnt = popcnt(hit);
    end

    assign last = (idx == IW'(NS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_eq    <= 1'b0;
            match_count  <= '0;
            match_parity <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            mask_q       <= '0;
            idx          <= '0;
            eq_acc       <= 1'b0;
            cnt_acc      <= '0;
            par_acc      <= 1'b0;
        end else if (clr) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_eq    <= 1'b0;
            match_count  <= '0;
            match_parity <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        mask_q  <= mask;
                        idx     <= '0;
                        eq_acc  <= 1'b1;
                        cnt_acc <= '0;
                        par_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    eq_acc  <= eq_acc & slice_eq;
                    cnt_acc <= cnt_acc + slice_cnt;
                    par_acc <= par_acc ^ (^hit);
                    if (last) begin
                        // Fold the final slice straight into the outputs.
                        result_eq    <= eq_acc & slice_eq;
                        match_count  <= cnt_acc + slice_cnt;
                        match_parity <= par_acc ^ (^hit);
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_compare_seq.sv
// Directed bench for xnor_compare_seq at WIDTH=8, SLICE=2 with hand-computed results.
module tb_xnor_compare_seq;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int NS = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  mask = '0;
    logic          busy, done, result_eq, match_parity;
    logic [CW-1:0] match_count;

    int total = 0;
    int bad = 0;

    xnor_compare_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .a(a), .b(b), .mask(mask),
        .busy(busy), .done(done), .result_eq(result_eq),
        .match_count(match_count), .match_parity(match_parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] tm);
        a = ta;
        b = tb_v;
        mask = tm;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!done && n < 20) begin
            if (busy) busy_n++;
            step();
            n++;
        end
    endtask

    task automatic chk_res(input string tag, input logic e, input logic [CW-1:0] c, input logic p);
        chk({tag, ".eq"}, result_eq, e);
        chk({tag, ".cnt"}, match_count, c);
        chk({tag, ".par"}, match_parity, p);
    endtask

    task automatic run_cmp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic [W-1:0] tm, input logic e, input logic [CW-1:0] c, input logic p);
        int n, bn;
        start_cmp(ta, tb_v, tm);
        wait_done(n, bn);
        chk({tag, ".lat"}, n, NS);
        chk({tag, ".busycyc"}, bn, NS);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy_at_done"}, busy, 1'b0);
        chk_res(tag, e, c, p);
        step();
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk_res({tag, ".hold"}, e, c, p);
    endtask

    initial begin
        int n, bn, dn;

        // Reset state
        step();
        step();
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk_res("rst", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        step();

        // Basic compares
        run_cmp("t1", 8'hA5, 8'hA5, 8'h00, 1'b1, 4'd8, 1'b0);
        run_cmp("t2", 8'hFF, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);
        run_cmp("t3a", 8'hF0, 8'hF1, 8'h01, 1'b1, 4'd7, 1'b1);
        run_cmp("t3b", 8'hF0, 8'hF1, 8'hFF, 1'b1, 4'd0, 1'b0);

        // Start and operand changes while busy are ignored
        start_cmp(8'h0F, 8'h0F, 8'h00);
        step();
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n, bn);
        chk("t4.lat", n + 2, NS);
        chk("t4.done", done, 1'b1);
        chk_res("t4", 1'b1, 4'd8, 1'b0);
        step();
        chk("t4.done_pulse", done, 1'b0);

        // Back-to-back: restart in the DONE cycle
        start_cmp(8'h3C, 8'h3D, 8'h00);
        wait_done(n, bn);
        chk("t5a.lat", n, NS);
        chk("t5a.done", done, 1'b1);
        chk_res("t5a", 1'b0, 4'd7, 1'b1);
        start_cmp(8'h00, 8'h00, 8'h00);
        chk("t5b.busy", busy, 1'b1);
        chk("t5b.done_low", done, 1'b0);
        chk_res("t5b.hold", 1'b0, 4'd7, 1'b1);
        wait_done(n, bn);
        chk("t5b.lat", n, NS);
        chk("t5b.done", done, 1'b1);
        chk_res("t5b", 1'b1, 4'd8, 1'b0);
        step();

        // clr during RUN aborts without a done pulse
        start_cmp(8'h5A, 8'h5A, 8'h00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t6clr.busy", busy, 1'b0);
        chk("t6clr.done", done, 1'b0);
        chk_res("t6clr", 1'b0, 4'd0, 1'b0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) dn++;
        end
        chk("t6clr.no_done", dn, 0);

        // Asynchronous reset mid-run
        run_cmp("t6pre", 8'h0F, 8'h0F, 8'h00, 1'b1, 4'd8, 1'b0);
        start_cmp(8'hAA, 8'hAA, 8'h00);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6rst.busy", busy, 1'b0);
        chk("t6rst.done", done, 1'b0);
        chk_res("t6rst", 1'b0, 4'd0, 1'b0);
        #3;
        rst_n = 1'b1;
        step();
        run_cmp("t6post", 8'h33, 8'h31, 8'h00, 1'b0, 4'd7, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xnor_compare_seq.md
Name: xnor_compare_seq

Overview:
- Parametrised, sequential successor to the two-input NOR-built XNOR cell.
- Compares two WIDTH-bit operands slice by slice. SLICE bits are processed per clock using the NOR-based XNOR per-bit function.
- A per-bit mask excludes bits from the comparison.
- Reports equality, match count and match parity with a start/done handshake.
- Sits as the comparison unit behind the guide's combinational gate cells, feeding later datapath/ALU exercises.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of SLICE and ≥ SLICE.
- SLICE, 4, bits compared per clock cycle.
- NS (derived, not overridable): WIDTH/SLICE, number of RUN cycles.
- CW (derived): $clog2(WIDTH+1), width of match_count.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a compare. Sampled on rising edge.
- clr  input  1  synchronous abort/clear.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- mask  input  WIDTH  1 = bit ignored (treated as equal, not counted), captured when start is accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse, results valid.
- result_eq  output  1  1 when every unmasked bit of a equals b.
- match_count  output  CW  number of unmasked bit positions where a == b.
- match_parity  output  1  XOR-reduction of the unmasked match bits (1 = odd number of matches).

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State = IDLE.
  - busy, done, result_eq, match_count, match_parity = 0.
  - Internal operand/mask registers and slice index = 0.
- States:
  - IDLE: busy=0, done=0, outputs hold last results. If start=1 and clr=0: capture a, b, mask; clear accumulators (eq_acc=1, cnt=0, par=0); slice index=0; go to RUN.
  - RUN: busy=1. Each cycle processes slice i (bits [i*SLICE +: SLICE]).
    - Per bit: m = ~(a^b) | mask.
    - eq_acc &= &m.
    - cnt += popcount(~(a^b) & ~mask).
    - par ^= ^(~(a^b) & ~mask).
    - When i == NS-1, go to DONE; otherwise i++. No early exit: latency is fixed.
  - DONE: busy=0, done=1 for exactly this cycle. result_eq/match_count/match_parity load from accumulators on the RUN→DONE edge and hold until the next accepted start.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back; period NS+1 cycles).
    - Otherwise go to IDLE.
- Latency: start accepted at edge T0; done is high during the cycle after edge T0+NS. Results are stable from that edge.
- start while busy (RUN): ignored. Operands are not recaptured and no queueing occurs.
- clr=1 (synchronous, highest priority after reset):
  - In any state: next state IDLE, busy=0, done=0.
  - result_eq, match_count, match_parity cleared to 0. No done is generated for an aborted run.
  - clr and start in the same cycle: clr wins, start is dropped.
- Output results change only on the RUN→DONE transition, on clr or on reset. They are never updated mid-run.
- Boundary cases:
  - mask all ones: result_eq=1, match_count=0, match_parity=0.
  - All bits equal with no mask: match_count=WIDTH; this must not overflow CW.
  - Operand inputs changing during RUN must not affect the result.
- Purely synchronous datapath. No combinational path from inputs to outputs.

Test Plan:
- Use WIDTH=8, SLICE=2 (NS=4) for all scenarios.
1. a=8'hA5, b=8'hA5, mask=0, start pulse → busy for 4 cycles; done 4 cycles after start edge with result_eq=1, match_count=8, match_parity=0.
2. a=8'hFF, b=8'h00, mask=0 → result_eq=0, match_count=0, match_parity=0.
3. a=8'hF0, b=8'hF1, mask=8'h01 → result_eq=1, match_count=7, match_parity=1. Then mask=8'hFF → result_eq=1, match_count=0, match_parity=0.
4. Start a=8'h0F, b=8'h0F; at RUN cycle 2 pulse start with a=8'h00, b=8'hFF and change the a/b inputs → second start ignored; done at the original time with result_eq=1, match_count=8.
5. Start a=8'h3C, b=8'h3D, then start again in the DONE cycle with a=8'h00, b=8'h00 → first result eq=0, count=7, parity=1; second done exactly 4 cycles later with eq=1, count=8, parity=0.
6. Abort and reset during RUN:
   - clr=1 at RUN cycle 1 → IDLE next cycle, busy=0, outputs 0, no done pulse.
   - Separately, rst_n low mid-RUN (between clock edges) → all outputs 0 immediately.
   - After rst_n rises, a new start completes normally.
